grid_vga_renderer: RTL and testbench

GRID_VGA_RENDERER -- requirements
Module: grid_vga_renderer

---
 rtl/grid_vga_renderer_if.sv | 25 ++
 rtl/grid_vga_renderer.sv | 154 +++++++++++++++
 tb/tb_grid_vga_renderer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/grid_vga_renderer_if.sv
// Signal bundle between the life engine / display side and grid_vga_renderer:
// the cell grid goes in, the registered 800x600 VGA stream comes out.
interface grid_vga_renderer_if #(
  parameter int WIDTH  = 20,
  parameter int HEIGHT = 15
);
  logic [HEIGHT-1:0][WIDTH-1:0] grid;
  logic                         hsync;
  logic                         vsync;
  logic [3:0]                   red;
  logic [3:0]                   green;
  logic [3:0]                   blue;
  logic                         video_active;
  logic                         frame_tick;

  modport master (
    input  grid,
    output hsync, vsync, red, green, blue, video_active, frame_tick
  );

  modport slave (
    output grid,
    input  hsync, vsync, red, green, blue, video_active, frame_tick
  );
endinterface

// File: rtl/grid_vga_renderer.sv
// Renders a WIDTH x HEIGHT life grid as square cells on an 800x600 VGA raster
// (1056x628 total), latching the grid once per frame so a frame never tears.
module grid_vga_renderer #(
  parameter int WIDTH      = 20,
  parameter int HEIGHT     = 15,
  parameter int CELL       = 40,
  parameter int GRID_LINES = 1
) (
  input  logic                clk_40mhz,
  input  logic                reset,
  grid_vga_renderer_if.master vif
);

  localparam int SW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);

  localparam logic [10:0] H_LAST       = 11'd1055;
  localparam logic [10:0] H_VIS_END    = 11'd799;
  localparam logic [10:0] H_SYNC_START = 11'd840;
  localparam logic [10:0] H_SYNC_END   = 11'd967;

  localparam logic [9:0]  V_LAST       = 10'd627;
  localparam logic [9:0]  V_VIS_END    = 10'd599;
  localparam logic [9:0]  V_SNAP       = 10'd600;
  localparam logic [9:0]  V_SYNC_START = 10'd601;
  localparam logic [9:0]  V_SYNC_END   = 10'd604;

  localparam logic [SW-1:0] SUB_LAST   = SW'(CELL - 1);
  localparam logic [XW-1:0] CELL_X_END = XW'(WIDTH);
  localparam logic [YW-1:0] CELL_Y_END = YW'(HEIGHT);

  logic [10:0]                  r_hcount;
  logic [9:0]                   r_vcount;
  logic [SW-1:0]                r_sub_x;
  logic [XW-1:0]                r_cell_x;
  logic [SW-1:0]                r_sub_y;
  logic [YW-1:0]                r_cell_y;
  logic [HEIGHT-1:0][WIDTH-1:0] r_snap;
  logic                         r_hsync;
  logic                         r_vsync;
  logic [3:0]                   r_red;
  logic [3:0]                   r_green;
  logic [3:0]                   r_blue;
  logic                         r_video_active;
  logic                         r_frame_tick;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_visible;
  logic        w_border;
  logic        w_alive;
  logic        w_snap_load;
  logic        w_hsync;
  logic        w_vsync;
  logic [11:0] w_rgb;

  assign w_h_last    = (r_hcount == H_LAST);
  assign w_v_last    = (r_vcount == V_LAST);
  assign w_visible   = (r_hcount <= H_VIS_END) && (r_vcount <= V_VIS_END);
  assign w_snap_load = (r_hcount == '0) && (r_vcount == V_SNAP);
  assign w_hsync     = (r_hcount >= H_SYNC_START) && (r_hcount <= H_SYNC_END);
  assign w_vsync     = (r_vcount >= V_SYNC_START) && (r_vcount <= V_SYNC_END);
  assign w_border    = (GRID_LINES != 0) && ((r_sub_x == '0) || (r_sub_y == '0));
  assign w_alive     = r_snap[r_cell_y][r_cell_x];

  // Cell indices saturate at WIDTH/HEIGHT in blanking so they never wrap into a real cell.
  always_ff @(posedge clk_40mhz or negedge reset) begin
    if (!reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_sub_x  <= '0;
      r_cell_x <= '0;
      r_sub_y  <= '0;
      r_cell_y <= '0;
    end else if (w_h_last) begin
      r_hcount <= '0;
      r_sub_x  <= '0;
      r_cell_x <= '0;
      if (w_v_last) begin
        r_vcount <= '0;
        r_sub_y  <= '0;
        r_cell_y <= '0;
      end else begin
        r_vcount <= r_vcount + 10'd1;
        if (r_sub_y == SUB_LAST) begin
          r_sub_y <= '0;
          if (r_cell_y != CELL_Y_END) begin
            r_cell_y <= r_cell_y + YW'(1);
          end
        end else begin
          r_sub_y <= r_sub_y + SW'(1);
        end
      end
    end else begin
      r_hcount <= r_hcount + 11'd1;
      if (r_sub_x == SUB_LAST) begin
        r_sub_x <= '0;
        if (r_cell_x != CELL_X_END) begin
          r_cell_x <= r_cell_x + XW'(1);
        end
      end else begin
        r_sub_x <= r_sub_x + SW'(1);
      end
    end
  end

  always_comb begin
    w_rgb = 12'h000;
    if (w_visible) begin
      if (w_border) begin
        w_rgb = 12'h444;
      end else if (w_alive) begin
        w_rgb = 12'hFFF;
      end else begin
        w_rgb = 12'h003;
      end
    end
  end

  // One register stage for every output keeps syncs, colour and frame_tick aligned.
  always_ff @(posedge clk_40mhz or negedge reset) begin
    if (!reset) begin
      r_snap         <= '0;
      r_hsync        <= 1'b0;
      r_vsync        <= 1'b0;
      r_red          <= 4'h0;
      r_green        <= 4'h0;
      r_blue         <= 4'h0;
      r_video_active <= 1'b0;
      r_frame_tick   <= 1'b0;
    end else begin
      if (w_snap_load) begin
        r_snap <= vif.grid;
      end
      r_hsync        <= w_hsync;
      r_vsync        <= w_vsync;
      r_red          <= w_rgb[11:8];
      r_green        <= w_rgb[7:4];
      r_blue         <= w_rgb[3:0];
      r_video_active <= w_visible;
      r_frame_tick   <= w_snap_load;
    end
  end

  assign vif.hsync        = r_hsync;
  assign vif.vsync        = r_vsync;
  assign vif.red          = r_red;
  assign vif.green        = r_green;
  assign vif.blue         = r_blue;
  assign vif.video_active = r_video_active;
  assign vif.frame_tick   = r_frame_tick;

endmodule

// File: tb/tb_grid_vga_renderer.sv
// Scoreboard bench for grid_vga_renderer: a raster model derived from the cycle
// index predicts every pixel; a monitor compares selected lines of two instances.
module tb_grid_vga_renderer;

  localparam int     W     = 20;
  localparam int     H     = 15;
  localparam int     CELL  = 40;
  localparam int     HT    = 1056;
  localparam int     VT    = 628;
  localparam longint FRAME = 64'(HT) * 64'(VT);

  typedef logic [H-1:0][W-1:0] grid_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       va;
    logic       ft;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pix_t;

  typedef struct {
    bit   chk;
    int   x;
    int   y;
    pix_t a;
    pix_t b;
  } exp_t;

  localparam pix_t PIX00_A = '{hs: 1'b0, vs: 1'b0, va: 1'b1, ft: 1'b0, r: 4'h4, g: 4'h4, b: 4'h4};
  localparam pix_t PIX00_B = '{hs: 1'b0, vs: 1'b0, va: 1'b1, ft: 1'b0, r: 4'h0, g: 4'h0, b: 4'h3};

  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  longint st    = 0;
  grid_t  snapA = '0;
  grid_t  snapB = '0;
  exp_t   q[$];
  int     nVectors = 0;
  int     nMiss    = 0;

  always #12 clk = ~clk;

  grid_vga_renderer_if #(.WIDTH(W), .HEIGHT(H)) ifA ();
  grid_vga_renderer_if #(.WIDTH(W), .HEIGHT(H)) ifB ();

  grid_vga_renderer #(.WIDTH(W), .HEIGHT(H), .CELL(CELL), .GRID_LINES(1)) dutA (
    .clk_40mhz (clk),
    .reset     (rst_n),
    .vif       (ifA)
  );

  grid_vga_renderer #(.WIDTH(W), .HEIGHT(H), .CELL(CELL), .GRID_LINES(0)) dutB (
    .clk_40mhz (clk),
    .reset     (rst_n),
    .vif       (ifB)
  );

  function automatic pix_t refPixel(int x, int y, bit gl, grid_t snap);
    pix_t p;
    p    = '0;
    p.hs = (x >= 840) && (x <= 967);
    p.vs = (y >= 601) && (y <= 604);
    p.ft = (x == 0) && (y == 600);
    if (x < 800 && y < 600) begin
      p.va = 1'b1;
      if (gl && ((x % CELL) == 0 || (y % CELL) == 0)) {p.r, p.g, p.b} = 12'h444;
      else if (snap[y / CELL][x / CELL])              {p.r, p.g, p.b} = 12'hFFF;
      else                                            {p.r, p.g, p.b} = 12'h003;
    end
    return p;
  endfunction

  function automatic bit inWindow(int y);
    return y inside {0, 1, 2, 40, 41, 299, 300, 560, 561, 599, 600, 601, 602, 603, 604, 605, 627};
  endfunction

  function automatic grid_t randomGrid();
    grid_t g;
    for (int r = 0; r < H; r++) begin
      logic [31:0] v;
      v    = $urandom;
      g[r] = v[W-1:0];
    end
    return g;
  endfunction

  function automatic pix_t sampleA();
    return {ifA.hsync, ifA.vsync, ifA.video_active, ifA.frame_tick, ifA.red, ifA.green, ifA.blue};
  endfunction

  function automatic pix_t sampleB();
    return {ifB.hsync, ifB.vsync, ifB.video_active, ifB.frame_tick, ifB.red, ifB.green, ifB.blue};
  endfunction

  task automatic checkOutput(input string name, input int x, input int y, input pix_t act, input pix_t exp);
    nVectors++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s pixel(%0d,%0d): got hs=%b vs=%b va=%b ft=%b rgb=%h%h%h, expected hs=%b vs=%b va=%b ft=%b rgb=%h%h%h",
               name, x, y, act.hs, act.vs, act.va, act.ft, act.r, act.g, act.b,
               exp.hs, exp.vs, exp.va, exp.ft, exp.r, exp.g, exp.b);
    end
  endtask

  task automatic checkCount(input string name, input longint act, input longint exp);
    nVectors++;
    if (act != exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, " A"}, -1, -1, sampleA(), '0);
    checkOutput({name, " B"}, -1, -1, sampleB(), '0);
  endtask

  task automatic applyStimulus(input grid_t g);
    ifA.grid = g;
  endtask

  task automatic waitEdges(input longint n);
    while (st < n) @(negedge clk);
  endtask

  task automatic waitTick(input string name, input longint expEdges);
    while (ifA.frame_tick !== 1'b1 && st < expEdges + 100) @(negedge clk);
    checkCount(name, st, expEdges);
  endtask

  // Reference raster: cycle index st maps to (x,y) with plain division; the
  // model's snapshot is taken from the bench's own grid copy at pixel (0,600).
  always @(posedge clk or negedge rst_n) begin : model
    exp_t e;
    if (!rst_n) begin
      st    = 0;
      snapA = '0;
      snapB = '0;
      q.delete();
    end else begin
      e.x   = int'(st % HT);
      e.y   = int'((st / HT) % VT);
      e.chk = inWindow(e.y);
      e.a   = refPixel(e.x, e.y, 1'b1, snapA);
      e.b   = refPixel(e.x, e.y, 1'b0, snapB);
      q.push_back(e);
      if (e.x == 0 && e.y == 600) begin
        snapA = ifA.grid;
        snapB = ifB.grid;
      end
      st = st + 1;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && q.size() > 0) begin
      e = q.pop_front();
      if (e.chk) begin
        checkOutput("raster A", e.x, e.y, sampleA(), e.a);
        checkOutput("raster B", e.x, e.y, sampleB(), e.b);
      end
    end
  end

  initial begin : stimulus
    grid_t g1;
    grid_t g2;
    ifA.grid = randomGrid();
    ifB.grid = '1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("power-on reset");

    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first pixel A", 0, 0, sampleA(), PIX00_A);
    checkOutput("first pixel B", 0, 0, sampleB(), PIX00_B);

    // Grid changes mid-frame before any snapshot must stay invisible.
    waitEdges(300 * HT + 10);
    g1 = randomGrid();
    g1[0][0]     = 1'b1;
    g1[0][1]     = 1'b0;
    g1[H-1][W-1] = 1'b0;
    applyStimulus(g1);

    waitTick("first frame_tick latency", 600 * HT + 1);
    @(negedge clk);
    checkCount("frame_tick width", longint'(ifA.frame_tick), 0);

    // Toggle the lower-right cell at vcount 300: frame 1 must keep showing g1.
    waitEdges(FRAME + 300 * HT + 10);
    g2 = randomGrid();
    g2[H-1][W-1] = ~g1[H-1][W-1];
    applyStimulus(g2);

    // Abort frame 1 on line 599, just before its snapshot/frame_tick.
    waitEdges(FRAME + 599 * HT + 500);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkReset("mid-frame reset");
    #2 rst_n = 1'b1;

    waitTick("frame_tick latency after mid-frame reset", 600 * HT + 1);
    waitEdges(FRAME + 45 * HT);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
